// File: rtl/roi_norm_pkg.sv
// Shared widths, pixel type and FSM state encoding for the ROI contrast normalizer.
package roi_norm_pkg;

  localparam int NUM_PIX = 784;
  localparam int PIX_W   = 6;
  localparam int NUM_W   = 12;
  localparam int IDX_W   = 10;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t PIX_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    EMIT,
    EMIT_WAIT
  } norm_state_t;

endpackage

// File: rtl/roi_contrast_normalizer_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, start/done handshake.
module seq_divider
  import roi_norm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [PIX_W-1:0] divisor,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [PIX_W-1:0] rem;
  logic [PIX_W-1:0] dvs;
  logic [PIX_W:0]   trial;
  logic [PIX_W-1:0] rem_next;
  logic             ge;

  // The quotient register doubles as the dividend shift register: its MSB feeds the remainder.
  always_comb begin
    trial    = {rem, quotient[NUM_W-1]};
    ge       = (trial >= {1'b0, dvs});
    rem_next = ge ? PIX_W'(trial - {1'b0, dvs}) : trial[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running  <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (running) begin
        rem      <= rem_next;
        quotient <= {quotient[NUM_W-2:0], ge};
        cnt      <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end else if (start) begin
        if (divisor == '0) begin
          quotient <= '1;
          done     <= 1'b1;
        end else begin
          quotient <= dividend;
          rem      <= '0;
          dvs      <= divisor;
          cnt      <= CNT_W'(NUM_W);
          running  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/roi_contrast_normalizer.sv
// Buffers one 28x28 ROI frame, tracks min/max, then re-emits each pixel stretched to 0..63
// (optionally inverted); frames with too little contrast come out all-zero.
module roi_contrast_normalizer
  import roi_norm_pkg::*;
#(
  parameter int MIN_RANGE = 4,
  parameter bit INVERT    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             frame_err,
  output logic             busy,
  output logic [PIX_W-1:0] stat_min,
  output logic [PIX_W-1:0] stat_max
);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PIX - 1);
  localparam pix_t             MIN_RANGE_P = PIX_W'(MIN_RANGE);

  norm_state_t      state;
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] idx;
  pix_t             run_min;
  pix_t             run_max;
  pix_t             range_r;
  logic             flat;
  logic             rd_phase;

  logic             accept;
  logic [IDX_W-1:0] wr_addr;
  logic             rd_en;
  pix_t             rd_data;
  pix_t             diff_d;
  logic [NUM_W-1:0] num;
  pix_t             sat_q;

  logic             div_start;
  logic             div_done;
  logic [NUM_W-1:0] div_quo;

  pix_t mem [NUM_PIX];

  assign in_ready = !reset && ((state == IDLE) || (state == LOAD));
  assign busy     = !reset && (state != IDLE);

  always_comb begin
    accept  = in_valid && in_ready;
    wr_addr = (state == IDLE) ? '0 : count;
    rd_en   = (state == EMIT) && !rd_phase;
    diff_d  = INVERT ? (run_max - rd_data) : (rd_data - run_min);
    num     = NUM_W'(diff_d) * NUM_W'(63) + NUM_W'(range_r >> 1);
    sat_q   = div_quo[PIX_W-1:0];
    if (div_quo > NUM_W'(PIX_MAX)) sat_q = PIX_MAX;
  end

  // Frame buffer: simple dual-port RAM, registered read with one cycle of latency.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= in_pixel;
    if (rd_en) rd_data <= mem[idx];
  end

  seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (num),
    .divisor  (range_r),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      run_min   <= '0;
      run_max   <= '0;
      range_r   <= '0;
      flat      <= 1'b0;
      rd_phase  <= 1'b0;
      div_start <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
      stat_min  <= '0;
      stat_max  <= '0;
    end else begin
      div_start <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            run_min <= in_pixel;
            run_max <= in_pixel;
            count   <= IDX_W'(1);
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            if (in_pixel < run_min) run_min <= in_pixel;
            if (in_pixel > run_max) run_max <= in_pixel;
            // A full frame wins over in_last; an early in_last aborts the frame.
            if (count == LAST_IDX) begin
              state <= CALC;
            end else if (in_last) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else begin
              count <= count + IDX_W'(1);
            end
          end
        end
        CALC: begin
          range_r  <= run_max - run_min;
          stat_min <= run_min;
          stat_max <= run_max;
          flat     <= ((run_max - run_min) < MIN_RANGE_P);
          idx      <= '0;
          rd_phase <= 1'b0;
          state    <= EMIT;
        end
        EMIT: begin
          // Phase 0 issues the RAM read; phase 1 consumes the returned pixel.
          if (!rd_phase) begin
            rd_phase <= 1'b1;
          end else begin
            rd_phase  <= 1'b0;
            out_index <= idx;
            out_last  <= (idx == LAST_IDX);
            if (flat) begin
              out_pixel <= '0;
              out_valid <= 1'b1;
            end else begin
              div_start <= 1'b1;
            end
            state <= EMIT_WAIT;
          end
        end
        EMIT_WAIT: begin
          if (out_valid) begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (out_last) begin
                state <= IDLE;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= EMIT;
              end
            end
          end else if (div_done) begin
            out_pixel <= sat_q;
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
